// File: rtl/trap_seq.sv
// Trap sequencer: arbitrates exceptions, interrupts and mret, then walks the pipeline
// through drain, CSR commit and PC redirect. Optional drain timeout: KRV_TRAP_DRAIN_TIMEOUT_EN.
module trap_seq #(
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        exc_req,
    input  logic [3:0]  exc_code,
    input  logic [2:0]  int_pend,
    input  logic [2:0]  mie_en,
    input  logic        mstatus_mie,
    input  logic        mret,
    input  logic        pipe_idle,
    output logic        stall,
    output logic        flush,
    output logic        trap_commit,
    output logic        mie_clr,
    output logic        mie_restore,
    output logic [31:0] cause,
    output logic        redirect,
    output logic        redirect_sel,
    output logic        busy,
    output logic        drain_to
);
    typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, REDIRECT, RET} state_t;

    state_t      state_reg, state_next;
    logic [31:0] cause_reg, cause_next;
    logic [2:0]  int_ready;
    logic        int_ok;
    logic        accept;
    logic        drain_force;
    logic        flush_reg, trap_commit_reg, mie_clr_reg, mie_restore_reg;
    logic        redirect_reg, redirect_sel_reg, busy_reg;

    assign int_ready = int_pend & mie_en;
    assign int_ok    = mstatus_mie & (|int_ready);

`ifdef KRV_TRAP_DRAIN_TIMEOUT_EN
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

    logic [7:0] drain_cnt_reg;
    logic       drain_to_reg;

    // Force the commit on the DRAIN cycle that brings the count up to DRAIN_TIMEOUT.
    assign drain_force = !pipe_idle && (drain_cnt_reg == DRAIN_LAST);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            drain_cnt_reg <= 8'd0;
            drain_to_reg  <= 1'b0;
        end else if (state_reg == DRAIN) begin
            if (state_next != DRAIN)
                drain_cnt_reg <= 8'd0;
            else
                drain_cnt_reg <= drain_cnt_reg + 8'd1;
            if (drain_force)
                drain_to_reg <= 1'b1;
        end
    end

    assign drain_to = drain_to_reg;
`else
    logic unused_drain_timeout;
    assign unused_drain_timeout = ^8'(DRAIN_TIMEOUT);
    assign drain_force = 1'b0;
    assign drain_to    = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by reset so stall reads 0 while reset is held.
                if (cpu_rstn) begin
                    if (exc_req) begin
                        accept     = 1'b1;
                        cause_next = {28'h0, exc_code};
                        state_next = DRAIN;
                    end else if (mret) begin
                        accept     = 1'b1;
                        state_next = RET;
                    end else if (int_ok) begin
                        accept     = 1'b1;
                        state_next = DRAIN;
                        if (int_ready[2])
                            cause_next = 32'h8000_000B;
                        else if (int_ready[0])
                            cause_next = 32'h8000_0003;
                        else
                            cause_next = 32'h8000_0007;
                    end
                end
            end
            DRAIN:    if (pipe_idle || drain_force) state_next = COMMIT;
            COMMIT:   state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            RET:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so each lines up with its state.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_reg        <= IDLE;
            cause_reg        <= 32'h0;
            flush_reg        <= 1'b0;
            trap_commit_reg  <= 1'b0;
            mie_clr_reg      <= 1'b0;
            mie_restore_reg  <= 1'b0;
            redirect_reg     <= 1'b0;
            redirect_sel_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cause_reg        <= cause_next;
            flush_reg        <= (state_next == DRAIN) || (state_next == RET);
            trap_commit_reg  <= (state_next == COMMIT);
            mie_clr_reg      <= (state_next == COMMIT);
            mie_restore_reg  <= (state_next == RET);
            redirect_reg     <= (state_next == REDIRECT) || (state_next == RET);
            redirect_sel_reg <= (state_next == RET);
            busy_reg         <= (state_next != IDLE);
        end
    end

    assign stall        = (state_reg != IDLE) || accept;
    assign flush        = flush_reg;
    assign trap_commit  = trap_commit_reg;
    assign mie_clr      = mie_clr_reg;
    assign mie_restore  = mie_restore_reg;
    assign redirect     = redirect_reg;
    assign redirect_sel = redirect_sel_reg;
    assign busy         = busy_reg;
    assign cause        = cause_reg;

endmodule

// File: tb/tb_trap_seq.sv
// Scoreboard bench for trap_seq: directed requests queue their expected strobe cycles,
// a negedge monitor pops and compares every strobe the DUT presents.
`timescale 1ns/1ps
module tb_trap_seq;
`ifdef KRV_TRAP_DRAIN_TIMEOUT_EN
    localparam int DT = 4;
`else
    localparam int DT = 15;
`endif

    logic        cpu_clk, cpu_rstn;
    logic        exc_req, mstatus_mie, mret, pipe_idle;
    logic [3:0]  exc_code;
    logic [2:0]  int_pend, mie_en;
    logic        stall, flush, trap_commit, mie_clr, mie_restore;
    logic        redirect, redirect_sel, busy, drain_to;
    logic [31:0] cause;
    logic [7:0]  obs;

    typedef struct {
        int          cyc;
        logic [7:0]  vec;
        logic [31:0] cause;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_cause = 32'h0;

    trap_seq #(.DRAIN_TIMEOUT(DT)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .exc_req(exc_req), .exc_code(exc_code),
        .int_pend(int_pend), .mie_en(mie_en), .mstatus_mie(mstatus_mie), .mret(mret),
        .pipe_idle(pipe_idle), .stall(stall), .flush(flush), .trap_commit(trap_commit),
        .mie_clr(mie_clr), .mie_restore(mie_restore), .cause(cause), .redirect(redirect),
        .redirect_sel(redirect_sel), .busy(busy), .drain_to(drain_to)
    );

    // {stall, flush, trap_commit, mie_clr, mie_restore, redirect, redirect_sel, busy}
    assign obs = {stall, flush, trap_commit, mie_clr, mie_restore, redirect, redirect_sel, busy};

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        forever begin
            @(posedge cpu_clk);
            cyc++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge cpu_clk);
            if (cpu_rstn && (trap_commit || redirect || mie_clr || mie_restore)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d actual obs=%b cause=%h required none", cyc, obs, cause);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || obs !== e.vec || cause !== e.cause) begin
                        errors++;
                        $display("FAIL strobe actual cyc=%0d obs=%b cause=%h required cyc=%0d obs=%b cause=%h",
                                 cyc, obs, cause, e.cyc, e.vec, e.cause);
                    end else
                        $display("strobe ok cyc=%0d obs=%b cause=%h", cyc, obs, cause);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else
            $display("check ok %s = %h", name, act);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    // Trap accepted in cycle c with d extra DRAIN cycles: commit at c+2+d, redirect at c+3+d.
    task automatic push_trap(input int c, input int d, input logic [31:0] cs);
        exp_q.push_back('{c + 2 + d, 8'b1011_0001, cs});
        exp_q.push_back('{c + 3 + d, 8'b1000_0101, cs});
        last_cause = cs;
    endtask

    task automatic push_ret(input int c);
        exp_q.push_back('{c + 1, 8'b1100_1111, last_cause});
    endtask

    // Holds the request for one cycle; returns the cycle number and the stall seen in it.
    task automatic issue(input logic e, input logic [3:0] code, input logic [2:0] pend,
                         input logic [2:0] en, input logic ms, input logic mr,
                         output int c, output logic st);
        exc_req = e; exc_code = code; int_pend = pend; mie_en = en; mstatus_mie = ms; mret = mr;
        #1;
        st = stall;
        c = cyc;
        @(posedge cpu_clk);
        #1;
        exc_req = 1'b0; mret = 1'b0; int_pend = 3'b000;
    endtask

    initial begin
        int   c;
        int   n;
        logic st;

        cpu_rstn = 1'b0; exc_req = 1'b1; exc_code = 4'h0; int_pend = 3'b000; mie_en = 3'b000;
        mstatus_mie = 1'b0; mret = 1'b0; pipe_idle = 1'b1;
        #2;
        check("reset_outputs", {24'h0, obs}, 32'h0);
        check("reset_cause", cause, 32'h0);
        check("reset_drain_to", {31'h0, drain_to}, 32'h0);
        exc_req = 1'b0;
        @(posedge cpu_clk); @(posedge cpu_clk); #1;
        cpu_rstn = 1'b1;
        wait_cycles(2);

        // Exception, code 2, pipeline already idle.
        push_trap(cyc, 0, 32'h0000_0002);
        issue(1'b1, 4'h2, 3'b000, 3'b000, 1'b0, 1'b0, c, st);
        check("exc_accept_stall", {31'h0, st}, 32'h1);
        wait_cycles(2);
        check("exc_busy_cycle3", {31'h0, busy}, 32'h1);
        wait_cycles(1);
        check("exc_busy_cycle4", {31'h0, busy}, 32'h0);
        check("exc_cause", cause, 32'h0000_0002);

        // Interrupt priority and masking.
        push_trap(cyc, 0, 32'h8000_000B);
        issue(1'b0, 4'h0, 3'b111, 3'b111, 1'b1, 1'b0, c, st);
        wait_cycles(4);
        push_trap(cyc, 0, 32'h8000_0003);
        issue(1'b0, 4'h0, 3'b111, 3'b011, 1'b1, 1'b0, c, st);
        wait_cycles(4);
        push_trap(cyc, 0, 32'h8000_0007);
        issue(1'b0, 4'h0, 3'b010, 3'b111, 1'b1, 1'b0, c, st);
        wait_cycles(4);
        check("timer_cause", cause, 32'h8000_0007);

        issue(1'b0, 4'h0, 3'b111, 3'b111, 1'b0, 1'b0, c, st);
        check("masked_stall", {31'h0, st}, 32'h0);
        check("masked_busy", {31'h0, busy}, 32'h0);
        check("masked_cause_held", cause, 32'h8000_0007);
        wait_cycles(2);

        // Exception beats mret and a pending timer; any mie_restore is unexpected.
        push_trap(cyc, 0, 32'h0000_0005);
        issue(1'b1, 4'h5, 3'b010, 3'b111, 1'b1, 1'b1, c, st);
        wait_cycles(4);
        check("exc_mret_cause", cause, 32'h0000_0005);

        // mret alone, then mret with an external interrupt pending.
        push_ret(cyc);
        issue(1'b0, 4'h0, 3'b000, 3'b111, 1'b1, 1'b1, c, st);
        check("mret_accept_stall", {31'h0, st}, 32'h1);
        wait_cycles(1);
        check("mret_busy_cycle2", {31'h0, busy}, 32'h0);
        push_ret(cyc);
        issue(1'b0, 4'h0, 3'b100, 3'b111, 1'b1, 1'b1, c, st);
        wait_cycles(2);
        check("mret_int_cause_held", cause, 32'h0000_0005);

`ifndef KRV_TRAP_DRAIN_TIMEOUT_EN
        // pipe_idle low for 5 DRAIN cycles, high from the sixth.
        pipe_idle = 1'b0;
        push_trap(cyc, 5, 32'h0000_000C);
        issue(1'b1, 4'hC, 3'b000, 3'b000, 1'b0, 1'b0, c, st);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (cyc == c + 6) pipe_idle = 1'b1;
            if (flush && !mie_restore) n++;
            wait_cycles(1);
        end
        check("drain_length", n, 32'd6);
        check("drain_done_busy", {31'h0, busy}, 32'h0);
        check("drain_to_tied", {31'h0, drain_to}, 32'h0);
`else
        // pipe_idle stuck low: forced commit after DT DRAIN cycles.
        pipe_idle = 1'b0;
        push_trap(cyc, DT - 1, 32'h0000_000C);
        issue(1'b1, 4'hC, 3'b000, 3'b000, 1'b0, 1'b0, c, st);
        wait_cycles(DT + 2);
        check("timeout_drain_to", {31'h0, drain_to}, 32'h1);
        check("timeout_busy", {31'h0, busy}, 32'h0);
`endif

        // Reset while stuck in DRAIN aborts the trap with no trailing strobes.
        pipe_idle = 1'b0;
        issue(1'b1, 4'h9, 3'b000, 3'b000, 1'b0, 1'b0, c, st);
        wait_cycles(1);
        check("rst_pre_busy", {31'h0, busy}, 32'h1);
        #1;
        cpu_rstn = 1'b0;
        #1;
        check("rst_mid_outputs", {24'h0, obs}, 32'h0);
        check("rst_mid_cause", cause, 32'h0);
        check("rst_mid_drain_to", {31'h0, drain_to}, 32'h0);
        @(posedge cpu_clk); #1;
        cpu_rstn = 1'b1;
        pipe_idle = 1'b1;
        last_cause = 32'h0;
        wait_cycles(4);
        check("rst_after_busy", {31'h0, busy}, 32'h0);

        push_trap(cyc, 0, 32'h0000_000F);
        issue(1'b1, 4'hF, 3'b000, 3'b000, 1'b0, 1'b0, c, st);
        wait_cycles(5);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_seq.md
# trap_seq

Trap sequencer for the KRV core. It arbitrates between synchronous exceptions, the three machine-level interrupt sources and `mret`, then sequences the pipeline through stall, drain, CSR commit and PC redirect. It sits between the decode/execute stages, the interrupt sources (kplic, core timer, software) and the machine CSR/trap registers, and it owns the single trap-entry/trap-return path.

## Interface
- `DRAIN_TIMEOUT`, default 15: maximum DRAIN cycles before a forced commit. Only used when the timeout feature is compiled in. Range 1–255.

- `cpu_clk`  in  1  cpu clock
- `cpu_rstn`  in  1  asynchronous active-low reset
- `exc_req`  in  1  synchronous exception request from pipeline
- `exc_code`  in  4  exception code accompanying `exc_req`
- `int_pend`  in  3  pending interrupts: bit0 software, bit1 timer, bit2 external
- `mie_en`  in  3  per-source enables, same bit order as `int_pend`
- `mstatus_mie`  in  1  global machine interrupt enable
- `mret`  in  1  `mret` retiring in execute
- `pipe_idle`  in  1  pipeline drained, no outstanding bus transaction
- `stall`  out  1  hold fetch/decode
- `flush`  out  1  kill in-flight instructions
- `trap_commit`  out  1  one-cycle strobe to write mepc/mcause/mtval
- `mie_clr`  out  1  strobe: MPIE←MIE, MIE←0
- `mie_restore`  out  1  strobe: MIE←MPIE
- `cause`  out  32  latched mcause value
- `redirect`  out  1  one-cycle PC redirect strobe
- `redirect_sel`  out  1  0 = trap vector, 1 = mepc
- `busy`  out  1  state ≠ IDLE
- `drain_to`  out  1  sticky drain-timeout flag

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT, RET.
- Interrupt eligibility: `int_ok = mstatus_mie & |(int_pend & mie_en)`.
- Arbitration in IDLE, highest priority first:
  - `exc_req`
  - `mret`
  - interrupt, external > software > timer
- Exception accepted in IDLE: latch `cause = {28'h0, exc_code}`, go to DRAIN.
- Interrupt accepted in IDLE: latch cause `0x8000000B` (external), `0x80000003` (software) or `0x80000007` (timer), go to DRAIN.
- `mret` accepted in IDLE: go to RET.
- DRAIN:
  - `stall=1`, `flush=1`; 8-bit drain counter increments each cycle.
  - `pipe_idle=1` → COMMIT; the counter clears on leaving DRAIN.
- COMMIT: `trap_commit=1`, `mie_clr=1` for exactly one cycle, then REDIRECT.
- REDIRECT: `redirect=1`, `redirect_sel=0` for one cycle, then IDLE.
- RET: `flush=1`, `redirect=1`, `redirect_sel=1`, `mie_restore=1` for one cycle, then IDLE.
- `stall` is combinational: 1 in every non-IDLE state, and 1 in IDLE during any cycle in which a request is accepted.
- Requests arriving while not in IDLE are ignored, not queued. Pending interrupts are re-evaluated on the first IDLE cycle.
- Once accepted, a trap completes even if `int_pend` or `exc_req` deasserts.
- `cause` holds its value until the next acceptance.

## Timing
- Reset value of every output, `cause` and the counter is 0; state is IDLE.
- Reset asserted mid-sequence returns to IDLE asynchronously; no partial strobes follow.
- Trap latency, with acceptance in cycle 0 and `pipe_idle=1` from cycle 1:
  - DRAIN in cycle 1, COMMIT in cycle 2, REDIRECT in cycle 3, IDLE in cycle 4.
  - A new request can be accepted in cycle 4 at the earliest.
- `mret` latency: accepted in cycle 0, RET in cycle 1, IDLE in cycle 2.
- Simultaneous events in IDLE:
  - `exc_req` with `mret` → exception taken, `mret` dropped.
  - `mret` with interrupt → `mret` taken.
- `trap_commit` and `redirect` never assert in the same cycle. `mie_clr` and `mie_restore` never assert in the same cycle.

## Configuration
- `KRV_TRAP_DRAIN_TIMEOUT_EN` defined:
  - When the DRAIN counter reaches `DRAIN_TIMEOUT` without `pipe_idle`, go to COMMIT anyway.
  - Set `drain_to=1`; it clears only on reset.
- Not defined:
  - DRAIN waits indefinitely for `pipe_idle`.
  - `drain_to` is tied to 0; no counter logic is required.

## Test plan
- Exception with `exc_req=1`, `exc_code=2` in IDLE and `pipe_idle=1` → `cause=0x00000002`, `trap_commit` in cycle 2, `redirect=1` with `redirect_sel=0` in cycle 3, `busy=0` in cycle 4.
- Interrupt priority: `int_pend=3'b111`, `mie_en=3'b111`, `mstatus_mie=1` → `cause=0x8000000B`. Same inputs with `mie_en=3'b011` → `cause=0x80000003`. Same inputs with `mstatus_mie=0` → no trap.
- Simultaneous `exc_req=1`, `mret=1` and timer pending → exception cause latched, and no `mie_restore` at any point in the sequence.
- `mret` alone → `mie_restore=1`, `redirect=1`, `redirect_sel=1` in cycle 1, IDLE in cycle 2.
- `pipe_idle` held 0 for 5 cycles, then 1 → DRAIN lasts 6 cycles, then exactly one `trap_commit` follows.
- With `KRV_TRAP_DRAIN_TIMEOUT_EN` defined, `DRAIN_TIMEOUT=4` and `pipe_idle` stuck at 0 → COMMIT after the counter reaches 4 and `drain_to=1`. Then assert `cpu_rstn` low while in DRAIN → all outputs 0 immediately.
